demux_1to2_buffered: RTL and testbench

Routes a 64-bit word stream from one valid/ready source to one of two valid/ready sinks, selected per word by a 1-bit select. Each sink has its own small FIFO, so a stalled sink never blocks words bound for the other sink unless that word's own queue is full. It sits where a single producer must be split between two consumers, such as a write-back or result-routing path in the 64-bit RISC-V datapath. It is the inverse of the 2-to-1 select, with real buffering and flow control.

---
 rtl/demux_1to2_buffered_pkg.sv | 5 +
 rtl/demux_1to2_buffered_sync_fifo.sv | 58 +++++
 rtl/demux_1to2_buffered.sv | 59 +++++
 tb/tb_demux_1to2_buffered.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux_1to2_buffered_pkg.sv
// Shared constants for the buffered 1-to-2 word demultiplexer.
package demux_1to2_buffered_pkg;
  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 2;
endpackage

// File: rtl/demux_1to2_buffered_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head data reads 0 while empty.
module sync_fifo
  import demux_1to2_buffered_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Requests are qualified here so a push into a full or a pop from an
  // empty queue can never corrupt the pointers.
  assign w_push = push && (r_count != FULL_CNT);
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= data_in;
  end

  assign data_out = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
endmodule

// File: rtl/demux_1to2_buffered.sv
// Routes one valid/ready word stream to one of two buffered valid/ready sinks.
module demux_1to2_buffered
  import demux_1to2_buffered_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic [$clog2(DEPTH):0] out0_count,
  output logic [$clog2(DEPTH):0] out1_count
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on in_sel and registered occupancy, never on
  // outN_ready, so no combinational path crosses the block.
  logic w_full0, w_full1, w_empty0, w_empty1;
  logic w_push0, w_push1;

  assign in_ready = in_sel ? !w_full1 : !w_full0;
  assign w_push0  = in_valid && in_ready && !in_sel;
  assign w_push1  = in_valid && in_ready && in_sel;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push0),
    .pop      (out0_ready),
    .data_in  (in_data),
    .data_out (out0_data),
    .count    (out0_count),
    .full     (w_full0),
    .empty    (w_empty0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push1),
    .pop      (out1_ready),
    .data_in  (in_data),
    .data_out (out1_data),
    .count    (out1_count),
    .full     (w_full1),
    .empty    (w_empty1)
  );

  assign out0_valid = !w_empty0;
  assign out1_valid = !w_empty1;
endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed bench for demux_1to2_buffered with a queue-based reference model.
module tb_demux_1to2_buffered;
  localparam int W  = 64;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_sel = 1'b0;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b0, out1_ready = 1'b0;
  logic [W-1:0]  out0_data, out1_data;
  logic [CW-1:0] out0_count, out1_count;

  demux_1to2_buffered #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] got1[$];

  always @(posedge clk) begin
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      started = 1'b1;
    end else begin
      bit acc;
      acc = in_valid && (in_sel ? (exp_q1.size() < D) : (exp_q0.size() < D));
      if (out1_valid && out1_ready) got1.push_back(out1_data);
      if (out0_ready && exp_q0.size() > 0) void'(exp_q0.pop_front());
      if (out1_ready && exp_q1.size() > 0) void'(exp_q1.pop_front());
      if (acc && !in_sel) exp_q0.push_back(in_data);
      if (acc && in_sel)  exp_q1.push_back(in_data);
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", W'(in_ready),
            W'(in_sel ? (exp_q1.size() != D) : (exp_q0.size() != D)));
      check("out0_valid", W'(out0_valid), W'(exp_q0.size() != 0));
      check("out1_valid", W'(out1_valid), W'(exp_q1.size() != 0));
      check("out0_count", W'(out0_count), W'(exp_q0.size()));
      check("out1_count", W'(out1_count), W'(exp_q1.size()));
      if (exp_q0.size() != 0) check("out0_data", out0_data, exp_q0[0]);
      if (exp_q1.size() != 0) check("out1_data", out1_data, exp_q1[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic s, input logic [W-1:0] d,
                        input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // 1. reset then idle
    tick();
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out0_valid", W'(out0_valid), W'(0));
    check("rst_out1_valid", W'(out1_valid), W'(0));
    check("rst_counts", W'({out0_count, out1_count}), W'(0));
    check("rst_out0_data", out0_data, W'(0));
    check("rst_out1_data", out1_data, W'(0));

    // 2. A(sel0), B(sel1), C(sel0) with both sinks ready
    set_in(1'b1, 1'b0, W'('hA), 1'b1, 1'b1); tick();
    check("t2_out0_A", out0_data, W'('hA));
    set_in(1'b1, 1'b1, W'('hB), 1'b1, 1'b1); tick();
    check("t2_out1_B", out1_data, W'('hB));
    check("t2_out0_drained", W'(out0_valid), W'(0));
    set_in(1'b1, 1'b0, W'('hC), 1'b1, 1'b1); tick();
    check("t2_out0_C", out0_data, W'('hC));
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1); tick();

    // 3. sink 0 stalled: two accepted, third refused, sel1 still accepted
    set_in(1'b1, 1'b0, W'('h11), 1'b0, 1'b1); tick();
    set_in(1'b1, 1'b0, W'('h12), 1'b0, 1'b1); tick();
    set_in(1'b1, 1'b0, W'('h13), 1'b0, 1'b1);
    check("t3_full_count", W'(out0_count), W'(2));
    check("t3_full_ready", W'(in_ready), W'(0));
    tick();
    set_in(1'b1, 1'b1, W'('h21), 1'b0, 1'b1);
    check("t3_sel1_ready", W'(in_ready), W'(1));
    tick();
    check("t3_sel1_out", out1_data, W'('h21));

    // 4. full FIFO 0, same-cycle pop: refused, then accepted next cycle
    set_in(1'b1, 1'b0, W'('h13), 1'b1, 1'b1);
    check("t4_refused", W'(in_ready), W'(0));
    tick();
    check("t4_count_1", W'(out0_count), W'(1));
    set_in(1'b1, 1'b0, W'('h13), 1'b0, 1'b1);
    check("t4_ready_again", W'(in_ready), W'(1));
    tick();
    check("t4_count_2", W'(out0_count), W'(2));
    check("t4_head", out0_data, W'('h12));
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1); tick(); tick(); tick();
    check("t4_drained", W'(out0_count), W'(0));

    // 5. continuous sel1 stream 1..8
    got1.delete();
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 1'b1, W'(i), 1'b1, 1'b1);
      check($sformatf("t5_ready_%0d", i), W'(in_ready), W'(1));
      if (i > 1) check($sformatf("t5_valid_%0d", i), W'(out1_valid), W'(1));
      tick();
    end
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1); tick(); tick();
    check("t5_n_out", W'(got1.size()), W'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < got1.size()) check($sformatf("t5_order_%0d", i), got1[i], W'(i + 1));
    end

    // 6. reset with FIFO 0 holding two words
    set_in(1'b1, 1'b0, W'('h51), 1'b0, 1'b0); tick();
    set_in(1'b1, 1'b0, W'('h52), 1'b0, 1'b0); tick();
    check("t6_filled", W'(out0_count), W'(2));
    set_in(1'b1, 1'b0, W'('h53), 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("t6_valid_cleared", W'(out0_valid), W'(0));
    check("t6_count_cleared", W'(out0_count), W'(0));
    check("t6_data_cleared", out0_data, W'(0));
    set_in(1'b1, 1'b0, W'('h77), 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("t6_new_word", out0_data, W'('h77));
    check("t6_new_count", W'(out0_count), W'(1));
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
